hswish_arbiter: RTL and testbench
=================================

HSWISH_ARBITER -- requirements
Module: hswish_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one HSwish unit.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, Q-format sample width.
REQ-003 SHALL have parameter HS_LATENCY, default 5, cycles from hs_en to hs_valid.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8 (power of two), result buffer depth.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-requester sample valid.
REQ-008 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, packed samples with requester i in slice i.
REQ-009 SHALL have port req_ready, output, NUM_REQ, one-hot grant.
REQ-010 SHALL have port hs_en, output, 1, issue strobe to the HSwish unit.
REQ-011 SHALL have port hs_x, output, DATA_WIDTH, issued sample.
REQ-012 SHALL have port hs_y, input, DATA_WIDTH, HSwish result.
REQ-013 SHALL have port hs_valid, input, 1, HSwish result strobe.
REQ-014 SHALL have port rsp_valid, output, 1, response available.
REQ-015 SHALL have port rsp_ready, input, 1, consumer accept.
REQ-016 SHALL have port rsp_data, output, DATA_WIDTH, result.
REQ-017 SHALL have port rsp_id, output, $clog2(NUM_REQ), originating requester.
REQ-018 SHALL have port err, output, 1, sticky tag/strobe mismatch flag.

Function
REQ-019 SHALL grant at most one requester per cycle, round-robin, starting the search one index after the last granted requester.
REQ-020 SHALL let req_ready depend combinationally on req_valid and credit; a transfer occurs when req_valid[i] & req_ready[i].
REQ-021 SHALL register each transfer so that hs_en=1 and hs_x=granted data in the following cycle; hs_en=0 otherwise, with hs_x held.
REQ-022 SHALL keep occupancy = in-flight issues + FIFO entries, and grant only when occupancy < FIFO_DEPTH; the HSwish pipeline cannot stall.
REQ-023 SHALL update occupancy by +1 on transfer and -1 on response pop, leaving it unchanged when both occur in the same cycle.
REQ-024 SHALL push the requester ID into a HS_LATENCY-deep tag shift register with a valid bit on each hs_en.
REQ-025 SHALL write {tag ID, hs_y} into the FIFO when hs_valid=1, giving an accept-to-rsp_valid latency of HS_LATENCY+2 cycles on an idle, empty path.
REQ-026 SHALL present the FIFO head on rsp_valid, rsp_data and rsp_id, popping it on rsp_valid & rsp_ready; order SHALL be issue order.
REQ-027 SHALL set err, until reset, when hs_valid differs from the tag-valid bit at the tail of the tag shift register; the hs_y sample SHALL still be written when hs_valid=1.
REQ-028 SHALL allow a FIFO write and pop in the same cycle when full; the credit rule prevents overflow.
REQ-029 SHALL leave the round-robin pointer unchanged in cycles with no grant.

Reset
REQ-030 SHALL on rst=0, immediately and asynchronously, clear req_ready, hs_en, hs_x, rsp_valid, rsp_data, rsp_id, err, occupancy, tag valids and FIFO pointers, and set the pointer so requester 0 has first priority.
REQ-031 SHALL discard in-flight results when reset is asserted mid-operation; hs_valid pulses in the first HS_LATENCY cycles after release SHALL be ignored and SHALL NOT set err.

Structure
REQ-032 SHALL take DATA_WIDTH, FRAC_WIDTH, HS_LATENCY defaults and the response struct {id, data} from the shared package hswish_pkg.
REQ-033 SHALL implement the result buffer as sub-module hswish_rsp_fifo, a synchronous FIFO with count output.

Verification
REQ-034 SHALL cover: requester 0 sends 0x0100 with a 5-cycle HSwish model -> rsp_data=0x00AA, rsp_id=0, rsp_valid 7 cycles after accept.
REQ-035 SHALL cover: all 4 requesters continuously valid -> grants in order 0,1,2,3,0,... with one grant per cycle and responses in the same order.
REQ-036 SHALL cover: rsp_ready=0 with 10 requests offered -> exactly 8 accepted and req_ready held at 0; then rsp_ready=1 -> 8 pops followed by 2 further grants.
REQ-037 SHALL cover: full FIFO with pop and grant in the same cycle -> occupancy stays 8 with no loss or duplication.
REQ-038 SHALL cover: a spurious hs_valid pulse with no issue -> err=1 held until rst.
REQ-039 SHALL cover: reset asserted with 3 samples in flight -> outputs clear at once, no responses after release, err=0.

Source files
------------

// File: rtl/hswish_pkg.sv
// Shared defaults and the response record for the HSwish request arbiter.
// The response record follows the default requester count and sample width.
package hswish_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_WIDTH = 8;
  localparam int DEF_HS_LATENCY = 5;
  localparam int DEF_ID_WIDTH   = $clog2(DEF_NUM_REQ);

  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]   id;
    logic [DEF_DATA_WIDTH-1:0] data;
  } rsp_t;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic int rr_next(input int id, input int n);
    return (id + 1 == n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/hswish_rsp_fifo.sv
// Show-ahead synchronous FIFO holding HSwish results; a write and a read may
// share a cycle even when full, because the read frees the slot being written.
module hswish_rsp_fifo
  import hswish_pkg::*;
#(
  parameter int WIDTH = $bits(rsp_t),
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_rd   = rd_en && (count != '0);
  assign do_wr   = wr_en && ((count != (AW+1)'(DEPTH)) || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hswish_arbiter.sv
// Round-robin arbiter feeding one fixed-latency HSwish unit; results return in
// issue order through a credit-protected FIFO tagged with the requester ID.
module hswish_arbiter
  import hswish_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int HS_LATENCY = DEF_HS_LATENCY,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          hs_en,
  output logic [DATA_WIDTH-1:0]         hs_x,
  input  logic [DATA_WIDTH-1:0]         hs_y,
  input  logic                          hs_valid,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic                          err
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int OCC_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int BLANK_W = $clog2(HS_LATENCY + 1);

  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       grant_id;
  logic [ID_W-1:0]       idx;
  logic                  grant_any;
  logic [DATA_WIDTH-1:0] granted_data;
  logic [OCC_W-1:0]      occupancy;
  logic                  credit;
  logic                  xfer;
  logic                  pop;
  logic [ID_W-1:0]       issue_id;

  logic [HS_LATENCY-1:0] tag_v;
  logic [ID_W-1:0]       tag_id [HS_LATENCY];
  logic [BLANK_W-1:0]    blank_cnt;
  logic                  ignore_hs;
  logic                  fifo_wr;
  logic [OCC_W-1:0]      fifo_count;
  rsp_t                  wr_rsp;
  rsp_t                  head;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  always_comb begin
    granted_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) granted_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Occupancy counts issued-but-unpopped samples, so the FIFO can never overflow.
  assign credit = occupancy < OCC_W'(FIFO_DEPTH);

  always_comb begin
    req_ready = '0;
    if (rst && credit && grant_any) req_ready[grant_id] = 1'b1;
  end

  assign xfer = |req_ready;
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      hs_en    <= 1'b0;
      hs_x     <= '0;
      issue_id <= '0;
    end else begin
      hs_en <= xfer;
      if (xfer) begin
        rr_ptr   <= ID_W'(rr_next(int'(grant_id), NUM_REQ));
        hs_x     <= granted_data;
        issue_id <= grant_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else begin
      case ({xfer, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v <= '0;
      for (int i = 0; i < HS_LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= hs_en;
      tag_id[0] <= issue_id;
      for (int i = 1; i < HS_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // Strobes from work issued before a reset can still arrive just after release.
  assign ignore_hs = (blank_cnt != '0) && !tag_v[HS_LATENCY-1];
  assign fifo_wr   = hs_valid && !ignore_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank_cnt <= BLANK_W'(HS_LATENCY);
      err       <= 1'b0;
    end else begin
      if (blank_cnt != '0) blank_cnt <= blank_cnt - BLANK_W'(1);
      if ((hs_valid != tag_v[HS_LATENCY-1]) && !ignore_hs) err <= 1'b1;
    end
  end

  always_comb begin
    wr_rsp      = '0;
    wr_rsp.id   = tag_id[HS_LATENCY-1];
    wr_rsp.data = hs_y;
  end

  hswish_rsp_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (wr_rsp),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count)
  );

  assign rsp_valid = fifo_count != '0;
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign rsp_id    = rsp_valid ? head.id   : '0;

endmodule

// File: tb/tb_hswish_arbiter.sv
// Directed bench for hswish_arbiter: a behavioural HSwish unit, a response
// scoreboard, a vector table for single transfers and hand sequences for corners.
module tb_hswish_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 5;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           hs_en;
  logic [W-1:0]   hs_x;
  logic [W-1:0]   hs_y;
  logic           hs_valid;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           err;

  int n_checks = 0;
  int n_fail   = 0;
  int sb_pops  = 0;
  int accepted = 0;

  always #5 clk = ~clk;

  hswish_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (W),
    .HS_LATENCY (L),
    .FIFO_DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hs_en     (hs_en),
    .hs_x      (hs_x),
    .hs_y      (hs_y),
    .hs_valid  (hs_valid),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .err       (err)
  );

  // Q8.8 hard-swish: x * clamp(x + 3, 0, 6) / 6, truncated toward zero.
  function automatic logic [15:0] hs_fn(input logic [15:0] x);
    int xi;
    int t;
    int y;
    xi = int'(signed'(x));
    t  = xi + 768;
    if (t < 0) t = 0;
    if (t > 1536) t = 1536;
    y = (xi * t) / 1536;
    return y[15:0];
  endfunction

  // HSwish unit: fixed latency, not reset, with an injectable spurious strobe.
  logic [L-1:0] pipe_v = '0;
  logic [W-1:0] pipe_y [L];
  logic         spur;
  logic [W-1:0] spur_y;

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[L-2:0], hs_en};
    pipe_y[0] <= hs_fn(hs_x);
    for (int i = 1; i < L; i++) pipe_y[i] <= pipe_y[i-1];
  end

  assign hs_valid = pipe_v[L-1] | spur;
  assign hs_y     = spur ? spur_y : pipe_y[L-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];

  // Scoreboard: accepted samples are expected back in acceptance order.
  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (rst) begin
      if (rsp_valid && rsp_ready) begin
        sb_pops++;
        checkOutput("rsp_has_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("sb_rsp_id", 32'(rsp_id), 32'(e.id));
          checkOutput("sb_rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id   = 2'(i);
          e.data = hs_fn(req_data[i*W +: W]);
          exp_q.push_back(e);
        end
      end
    end
  end

  typedef struct {
    int          id;
    logic [15:0] x;
    logic [15:0] y;
  } vec_t;

  vec_t vecs [7];

  task automatic applyStimulus(input int id, input logic [15:0] x, output int lat);
    logic got;
    @(posedge clk);
    #1;
    req_valid             = '0;
    req_valid[id]         = 1'b1;
    req_data[id*W +: W]   = x;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = req_ready[id];
    end
    checkOutput("accept", 32'(got), 1);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    checkOutput("hs_en_after_accept", 32'(hs_en), 1);
    checkOutput("hs_x_after_accept", 32'(hs_x), 32'(x));
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runCycles(input int n);
    logic tx;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      tx = req_valid[1] & req_ready[1];
      @(posedge clk);
      #1;
      if (tx) begin
        accepted++;
        if (accepted < 10) req_data[W +: W] = 16'h0080 + 16'(accepted) * 16'h0040;
        else req_valid = '0;
      end
    end
  endtask

  task automatic doReset();
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (L + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int cnt;

    vecs[0] = '{0, 16'h0100, 16'h00AA};
    vecs[1] = '{1, 16'h0200, 16'h01AA};
    vecs[2] = '{2, 16'h0400, 16'h0400};
    vecs[3] = '{3, 16'hFF00, 16'hFFAB};
    vecs[4] = '{1, 16'hFD00, 16'h0000};
    vecs[5] = '{2, 16'h0000, 16'h0000};
    vecs[6] = '{0, 16'hFE00, 16'hFFAB};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    spur      = 1'b0;
    spur_y    = '0;

    #1 rst = 1'b0;
    req_valid = '1;
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 0);
    checkOutput("reset_hs_en", 32'(hs_en), 0);
    checkOutput("reset_hs_x", 32'(hs_x), 0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset_rsp_data", 32'(rsp_data), 0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 0);
    checkOutput("reset_err", 32'(err), 0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (L + 2) @(posedge clk);
    #1;

    // Single transfers on an idle path.
    foreach (vecs[v]) begin
      applyStimulus(vecs[v].id, vecs[v].x, lat);
      checkOutput("vec_latency", 32'(lat), 7);
      checkOutput("vec_rsp_data", 32'(rsp_data), 32'(vecs[v].y));
      checkOutput("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
      repeat (3) @(posedge clk);
    end
    checkOutput("vec_err", 32'(err), 0);

    // All requesters continuously valid from a fresh reset.
    doReset();
    sb_pops = 0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'(256 * (i + 1));
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
    end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (20) @(negedge clk);
    checkOutput("rr_pops", 32'(sb_pops), 8);
    checkOutput("rr_queue_empty", 32'(exp_q.size()), 0);

    // Back-pressure: ten samples offered with the consumer stalled.
    doReset();
    sb_pops   = 0;
    accepted  = 0;
    rsp_ready = 1'b0;
    req_data[W +: W] = 16'h0080;
    req_valid = 4'b0010;
    runCycles(30);
    @(negedge clk);
    checkOutput("bp_accepted", 32'(accepted), 8);
    checkOutput("bp_req_ready_held", 32'(req_ready), 0);
    checkOutput("bp_rsp_valid", 32'(rsp_valid), 1);
    checkOutput("bp_no_pops", 32'(sb_pops), 0);

    // One pop on a full path lets exactly one more sample in.
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    runCycles(15);
    @(negedge clk);
    checkOutput("full_swap_accepted", 32'(accepted), 9);
    checkOutput("full_swap_pops", 32'(sb_pops), 1);
    checkOutput("full_swap_req_ready", 32'(req_ready), 0);

    @(posedge clk);
    #1 rsp_ready = 1'b1;
    runCycles(40);
    checkOutput("drain_accepted", 32'(accepted), 10);
    checkOutput("drain_pops", 32'(sb_pops), 10);
    checkOutput("drain_queue_empty", 32'(exp_q.size()), 0);

    // Spurious result strobe with nothing issued.
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("spur_err_before", 32'(err), 0);
    @(posedge clk);
    #1;
    spur   = 1'b1;
    spur_y = 16'h1234;
    @(posedge clk);
    #1 spur = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("spur_err_set", 32'(err), 1);
    checkOutput("spur_rsp_valid", 32'(rsp_valid), 1);
    checkOutput("spur_rsp_data", 32'(rsp_data), 32'h1234);
    repeat (10) @(negedge clk);
    checkOutput("spur_err_held", 32'(err), 1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("spur_err_cleared", 32'(err), 0);
    checkOutput("spur_rsp_cleared", 32'(rsp_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (L + 2) @(posedge clk);
    #1;

    // Reset with three samples inside the HSwish unit.
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'h0300 + 16'(i);
    req_valid = '1;
    cnt = 0;
    for (int c = 0; c < 10 && cnt < 3; c++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) cnt++;
    end
    checkOutput("inflight_issued", 32'(cnt), 3);
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1 req_valid = '1;
    #1 rst = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("inflight_req_ready", 32'(req_ready), 0);
    checkOutput("inflight_hs_en", 32'(hs_en), 0);
    checkOutput("inflight_hs_x", 32'(hs_x), 0);
    checkOutput("inflight_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("inflight_err", 32'(err), 0);
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    sb_pops = 0;
    repeat (25) @(negedge clk);
    checkOutput("post_reset_pops", 32'(sb_pops), 0);
    checkOutput("post_reset_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("post_reset_err", 32'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
